// File: rtl/time_of_day_hour_generator_pkg.sv
// Shared widths, day-window bounds and FSM encoding for the time-of-day generator.
// Optional DAYNIGHT_FLAG_EN builds use is_daytime() for the day_night flag.
package tod_pkg;

    localparam int HOURS_W   = 5;
    localparam int MIN_W     = 6;
    localparam int DAY_START = 6;
    localparam int DAY_END   = 17;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        LOADING = 2'd2
    } tod_state_t;

    function automatic logic is_daytime(input logic [HOURS_W-1:0] hours);
        return (int'(hours) >= DAY_START) && (int'(hours) <= DAY_END);
    endfunction

endpackage

// File: rtl/time_of_day_hour_generator_if.sv
// Valid/ready time-load port: the master offers hours/minutes, the slave accepts
// or flags an illegal value with a one-cycle set_err pulse.
interface time_of_day_hour_generator_if;
    import tod_pkg::*;

    logic               set_valid;
    logic               set_ready;
    logic [HOURS_W-1:0] set_hours;
    logic [MIN_W-1:0]   set_minutes;
    logic               set_err;

    modport master (
        output set_valid, set_hours, set_minutes,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_hours, set_minutes,
        output set_ready, set_err
    );

endinterface

// File: rtl/time_of_day_hour_generator_mod_n_counter.sv
// Modulo-N counter with synchronous load; wrap is asserted combinationally on the
// increment that takes the count from N-1 back to 0, so counters can be chained.
module mod_n_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    assign wrap  = inc && (count_reg == W'(N - 1));
    assign value = count_reg;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (wrap) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/time_of_day_hour_generator.sv
// Free-running hours/minutes clock driven by tick_in, with a valid/ready time load.
// Define DAYNIGHT_FLAG_EN to add the registered day_night output (1 for hours 6..17).
module time_of_day_hour_generator
    import tod_pkg::*;
#(
    parameter int TICKS_PER_MIN = 60,
    parameter int MIN_PER_HOUR  = 60,
    parameter int HOURS_PER_DAY = 24
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         run,
    input  logic                         tick_in,
    time_of_day_hour_generator_if.slave  set_bus,
    output logic [HOURS_W-1:0]           hours_out,
    output logic [MIN_W-1:0]             minutes_out,
    output logic                         hour_strobe,
`ifdef DAYNIGHT_FLAG_EN
    output logic                         day_night,
`endif
    output logic                         day_wrap
);

    localparam int TICK_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

    tod_state_t  state_reg;
    tod_state_t  state_next;
    logic        set_ready_reg;
    logic        set_ready_next;
    logic        set_err_reg;
    logic        hour_strobe_reg;
    logic        day_wrap_reg;

    logic        handshake;
    logic        load_legal;
    logic        load_en;
    logic        count_en;
    logic        tick_wrap;
    logic        min_wrap;
    logic        hour_wrap;
    logic [TICK_W-1:0] unused_tick_count;

    assign handshake  = set_bus.set_valid && set_ready_reg;
    assign load_legal = (int'(set_bus.set_hours) < HOURS_PER_DAY) &&
                        (int'(set_bus.set_minutes) < MIN_PER_HOUR);
    assign load_en    = handshake && load_legal;
    // A coincident handshake always wins over the tick, which is then dropped.
    assign count_en   = (state_reg == RUNNING) && tick_in && !handshake;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STOPPED: if (run)  state_next = RUNNING;
            RUNNING: if (!run) state_next = STOPPED;
            LOADING: state_next = run ? RUNNING : STOPPED;
            default: state_next = STOPPED;
        endcase
        if (handshake) begin
            state_next = LOADING;
        end
        set_ready_next = (state_next != LOADING);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= STOPPED;
            set_ready_reg   <= 1'b0;
            set_err_reg     <= 1'b0;
            hour_strobe_reg <= 1'b0;
            day_wrap_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            set_ready_reg   <= set_ready_next;
            set_err_reg     <= handshake && !load_legal;
            hour_strobe_reg <= min_wrap;
            day_wrap_reg    <= hour_wrap;
        end
    end

    mod_n_counter #(.N(TICKS_PER_MIN), .W(TICK_W)) u_ticks (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (count_en),
        .load       (load_en),
        .load_value ('0),
        .value      (unused_tick_count),
        .wrap       (tick_wrap)
    );

    mod_n_counter #(.N(MIN_PER_HOUR), .W(MIN_W)) u_minutes (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (tick_wrap),
        .load       (load_en),
        .load_value (set_bus.set_minutes),
        .value      (minutes_out),
        .wrap       (min_wrap)
    );

    mod_n_counter #(.N(HOURS_PER_DAY), .W(HOURS_W)) u_hours (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (min_wrap),
        .load       (load_en),
        .load_value (set_bus.set_hours),
        .value      (hours_out),
        .wrap       (hour_wrap)
    );

`ifdef DAYNIGHT_FLAG_EN
    logic [HOURS_W-1:0] hours_next;
    logic               day_night_reg;

    // Mirrors the hour counter's next value so the flag lands with hours_out.
    always_comb begin
        hours_next = hours_out;
        if (load_en) begin
            hours_next = set_bus.set_hours;
        end else if (hour_wrap) begin
            hours_next = '0;
        end else if (min_wrap) begin
            hours_next = hours_out + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            day_night_reg <= 1'b0;
        end else begin
            day_night_reg <= is_daytime(hours_next);
        end
    end

    assign day_night = day_night_reg;
`endif

    assign set_bus.set_ready = set_ready_reg;
    assign set_bus.set_err   = set_err_reg;
    assign hour_strobe       = hour_strobe_reg;
    assign day_wrap          = day_wrap_reg;

endmodule

// File: tb/tb_time_of_day_hour_generator.sv
// Scoreboard bench: the driver pushes per-cycle expectations from a tick-total model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_time_of_day_hour_generator;

    localparam int TPM       = 2;
    localparam int HOUR_TCK  = 60 * TPM;
    localparam int DAY_TCK   = 24 * HOUR_TCK;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       tick_in;
    logic [4:0] hours_out;
    logic [5:0] minutes_out;
    logic       hour_strobe;
    logic       day_wrap;
`ifdef DAYNIGHT_FLAG_EN
    logic       day_night;
`endif

    time_of_day_hour_generator_if set_bus();

    time_of_day_hour_generator #(
        .TICKS_PER_MIN (TPM),
        .MIN_PER_HOUR  (60),
        .HOURS_PER_DAY (24)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .tick_in     (tick_in),
        .set_bus     (set_bus),
        .hours_out   (hours_out),
        .minutes_out (minutes_out),
        .hour_strobe (hour_strobe),
`ifdef DAYNIGHT_FLAG_EN
        .day_night   (day_night),
`endif
        .day_wrap    (day_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int h;
        int m;
        int hs;
        int dw;
        int err;
        int rdy;
        int dn;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: time held as a total tick count within the day.
    int   total = 0;
    bit   ready_now = 0;
    bit   prev_hs = 0;
    bit   prev_run = 0;
    bit   run_lvl = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            check("stale_expectation", e.due, cyc);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("hours_out", int'(hours_out), e.h);
            check("minutes_out", int'(minutes_out), e.m);
            check("hour_strobe", int'(hour_strobe), e.hs);
            check("day_wrap", int'(day_wrap), e.dw);
            check("set_err", int'(set_bus.set_err), e.err);
            check("set_ready", int'(set_bus.set_ready), e.rdy);
`ifdef DAYNIGHT_FLAG_EN
            check("day_night", int'(day_night), e.dn);
`endif
        end
    end

    task automatic step(input bit rst, input bit tk, input bit v, input int h, input int m);
        exp_t e;
        bit   hs;
        bit   counting;
        @(posedge clk);
        #1;
        reset_n             = !rst;
        run                 = run_lvl;
        tick_in             = tk;
        set_bus.set_valid   = v;
        set_bus.set_hours   = 5'(h);
        set_bus.set_minutes = 6'(m);
        e.hs  = 0;
        e.dw  = 0;
        e.err = 0;
        if (rst) begin
            total     = 0;
            ready_now = 0;
            prev_hs   = 0;
            prev_run  = 0;
            e.rdy     = 0;
        end else begin
            hs       = v && ready_now;
            counting = prev_run && !prev_hs;
            if (hs) begin
                if (h < 24 && m < 60) total = (h * 60 + m) * TPM;
                else e.err = 1;
            end else if (counting && tk) begin
                total = (total + 1) % DAY_TCK;
                e.hs  = (total % HOUR_TCK == 0) ? 1 : 0;
                e.dw  = (total == 0) ? 1 : 0;
            end
            ready_now = !hs;
            prev_hs   = hs;
            prev_run  = run_lvl;
            e.rdy     = ready_now ? 1 : 0;
        end
        e.h   = total / HOUR_TCK;
        e.m   = (total / TPM) % 60;
        e.dn  = (e.h >= 6 && e.h <= 17) ? 1 : 0;
        e.due = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        step(0, 1, 0, 0, 0);
    endtask

    task automatic load(input int h, input int m, input bit tk);
        step(0, tk, 1, h, m);
        $display("load %0d:%0d tick=%0d -> expect %0d:%0d err=%0d", h, m, tk,
                 total / HOUR_TCK, (total / TPM) % 60, exp_q[$].err);
    endtask

    initial begin
        reset_n             = 1'b0;
        run                 = 1'b0;
        tick_in             = 1'b0;
        set_bus.set_valid   = 1'b0;
        set_bus.set_hours   = '0;
        set_bus.set_minutes = '0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(2);

        run_lvl = 1;
        idle(2);
        load(5, 59, 0);  idle(1); tick(); tick();
        load(23, 59, 0); idle(1); tick(); tick();
        load(24, 10, 0); idle(1);
        load(12, 60, 0); idle(1);

        load(10, 30, 0); idle(1);
        run_lvl = 0;
        idle(2);
        repeat (10) tick();
        run_lvl = 1;
        idle(1);
        tick(); tick();

        load(8, 15, 1); idle(1);
        load(3, 0, 0); tick(); tick(); tick();

        for (int h = 0; h < 24; h++) begin
            load(h, 30, 0);
            idle(1);
        end

        for (int i = 0; i < 600; i++) begin
            bit rst_r;
            bit v_r;
            if ($urandom_range(0, 19) == 0) run_lvl = !run_lvl;
            rst_r = ($urandom_range(0, 99) == 0);
            v_r   = ($urandom_range(0, 9) == 0);
            if (rst_r) $display("random reset at cycle %0d", cyc);
            if (v_r && !rst_r)
                load($urandom_range(0, 25), $urandom_range(0, 62), 1'($urandom_range(0, 1)));
            else
                step(rst_r, 1'($urandom_range(0, 1)), v_r, $urandom_range(0, 23), $urandom_range(0, 59));
        end

        idle(2);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
